// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path, reused by the serializer
// and its seq_check neighbours.
package seq_pkg;

  typedef logic [0:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 1'b0;
  localparam seq_state_t ST_SHIFT = 1'b1;

  // Idle line level: high so a downstream zero-run detector sees no zeros.
  localparam logic IDLE_BIT_DEFAULT = 1'b1;

endpackage

// File: rtl/seq_div_cnt.sv
// Bit-period counter. tick looks one cycle ahead: it is high at an edge after
// which the count sits on the final cycle of the bit period.
module seq_div_cnt #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = (cnt_next == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter with a one-word holding register; each bit is
// held DIV cycles and consecutive words are sent without an idle gap.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   DIV       = 4,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int IW = $clog2(WIDTH) + 1;

  seq_state_t       state;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shnext;
  logic [IW-1:0]    idx;
  logic             hold_full;
  logic             last_cyc;
  logic             tick;
  logic             accept;
  logic             load;
  logic             advance;
  logic             finish;
  logic             cnt_clr;
  logic             cnt_en;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  assign accept  = din_valid && din_ready;
  assign finish  = (state == ST_SHIFT) && last_cyc && (idx == IW'(WIDTH - 1));
  assign advance = (state == ST_SHIFT) && last_cyc && !finish;
  assign load    = hold_full && ((state == ST_IDLE) || finish);
  assign cnt_clr = load || finish;
  assign cnt_en  = (state == ST_SHIFT) && !finish;
  assign shnext  = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg[WIDTH-1:1]};

  seq_div_cnt #(.DIV(DIV)) u_div_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tick (tick)
  );

  // Outputs are computed one edge ahead so out, out_valid and done are flops;
  // last_cyc marks the final cycle of the bit currently on out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      idx       <= '0;
      last_cyc  <= 1'b0;
      out       <= IDLE_BIT;
      out_valid <= 1'b0;
      done      <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      din_ready <= ~(accept | (hold_full & ~load));
      done      <= 1'b0;

      if (load) begin
        state     <= ST_SHIFT;
        shreg     <= hold;
        idx       <= '0;
        out       <= first_bit(hold);
        out_valid <= 1'b1;
        last_cyc  <= tick;
      end else if (finish) begin
        state     <= ST_IDLE;
        out       <= IDLE_BIT;
        out_valid <= 1'b0;
        last_cyc  <= 1'b0;
      end else if (advance) begin
        shreg    <= shnext;
        idx      <= idx + IW'(1);
        out      <= first_bit(shnext);
        last_cyc <= tick;
        done     <= tick && (idx == IW'(WIDTH - 2));
      end else if (state == ST_SHIFT) begin
        last_cyc <= tick;
        done     <= tick && (idx == IW'(WIDTH - 1));
      end
    end
  end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per word (2..32).
REQ-002 SHALL have parameter DIV, default 4: clock cycles per serial bit (>=1).
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-004 SHALL have parameter IDLE_BIT, default 1'b1: level on out when no word is being sent (1, so the downstream zero-run detector sees no zeros while idle).
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port din, input, WIDTH: parallel word to send.
REQ-008 SHALL have port din_valid, input, 1: din is valid this cycle.
REQ-009 SHALL have port din_ready, output, 1: block can accept a word this cycle.
REQ-010 SHALL have port out, output, 1: serial bit stream; feeds the sequence checker's in.
REQ-011 SHALL have port out_valid, output, 1: out carries a data bit (state SHIFT).
REQ-012 SHALL have port done, output, 1: one-cycle pulse in the last cycle of each word's last bit.

Function
REQ-013 SHALL accept a word on a clock edge where din_valid && din_ready; din is captured into a one-word holding register (hold_full set).
REQ-014 SHALL drive din_ready = ~hold_full from a register; no combinational path from din_valid to din_ready.
REQ-015 SHALL hold din_ready low while hold_full, including the cycle the holding register is emptied, so accept and unload never coincide.
REQ-016 SHALL implement FSM states IDLE and SHIFT.
REQ-017 IDLE: out = IDLE_BIT, out_valid = 0; if hold_full at an edge -> load shifter from hold, clear hold_full, bit index 0, cycle count 0, go SHIFT.
REQ-018 SHALL make the first data bit appear on out one cycle after the accept edge when idle (accept at edge E0 -> first bit after E1).
REQ-019 SHIFT: out = current bit of the shifter (order per MSB_FIRST), out_valid = 1; each bit is held exactly DIV cycles.
REQ-020 SHALL advance to the next bit when cycle count reaches DIV-1 (count wraps to 0); DIV = 1 gives one bit per cycle.
REQ-021 SHALL assert done in the final cycle of bit WIDTH-1 (DIV*WIDTH cycles after the load).
REQ-022 At the end of the last bit: if hold_full -> reload shifter from hold in the same edge and stay SHIFT (no idle gap); else -> IDLE.
REQ-023 SHALL size the cycle counter $clog2(DIV)+1 bits and the bit index $clog2(WIDTH)+1 bits; counters never exceed DIV-1 or WIDTH-1.
REQ-024 SHALL ignore din while din_ready = 0; the sender holds din and din_valid (no data loss, no overwrite of the holding register).
REQ-025 out, out_valid and done SHALL be registered outputs.

Reset
REQ-026 On rst = 1 at an edge SHALL set state IDLE, hold_full = 0, counters 0, out = IDLE_BIT, out_valid = 0, done = 0, din_ready = 0.
REQ-027 SHALL set din_ready = 1 on the first edge after rst deasserts.
REQ-028 Reset mid-word SHALL discard the word in flight and the held word; no done pulse is issued for either.

Structure
REQ-029 Shared package seq_pkg SHALL hold the state enumeration (IDLE, SHIFT) and the IDLE_BIT default constant, for reuse by seq_check neighbours.
REQ-030 Bit-period counting SHALL be a sub-module seq_div_cnt (params DIV; ports clk, rst, clr, en, tick) instantiated once.
REQ-031 Total RTL SHALL stay within 120-400 lines including the sub-module.

Verification (WIDTH=8, DIV=4, MSB_FIRST=1 unless noted)
REQ-032 Single word 8'hF0 accepted at E0 -> out_valid high for 32 cycles from E1; out = 1 for 16 cycles then 0 for 16; done in cycle 32; out = 1 afterwards.
REQ-033 Back-to-back 8'h00 then 8'h0F offered continuously -> 64 contiguous out_valid cycles, no IDLE gap, done twice; the downstream checker sees 12 consecutive zeros.
REQ-034 Third word offered while hold_full -> din_ready = 0 until the second word loads; all three words are sent in order, none lost.
REQ-035 rst asserted in bit 3 of 8'h00 -> next cycle out = 1, out_valid = 0, no done; din_ready = 1 one edge after rst drops.
REQ-036 MSB_FIRST=0, DIV=1, din = 8'h01 -> out sequence 1,0,0,0,0,0,0,0 on 8 consecutive cycles; done on the 8th.
